// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and data (D) sides; D side wins ties.
// Latency: request in IDLE at t -> mem_en at t+1 -> done at t+1+MEM_LAT; losing side stalls until a later IDLE.
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   output logic              i_stall,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              d_stall,
   output logic              err,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t            state_q, state_d;
   logic              gnt_d_q, gnt_d_d;
   logic              flush_q, flush_d;
   logic              err_q, err_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic d_req, d_bad;

   always_comb begin
      state_d     = state_q;
      gnt_d_d     = gnt_d_q;
      flush_d     = flush_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      mem_en_d    = 1'b0;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      d_req       = d_rd | d_wr;
      d_bad       = d_rd & d_wr;
      case (state_q)
         IDLE: begin
            flush_d = 1'b0;
            if (d_bad) err_d = 1'b1;
            if (d_req && !d_bad) begin
               gnt_d_d     = 1'b1;
               mem_addr_d  = {d_addr[ADDR_W-1:1], 1'b0};
               mem_wdata_d = d_wdata;
               mem_wr_d    = d_wr;
               mem_en_d    = 1'b1;
               state_d     = ISSUE;
               if (d_addr[0]) err_d = 1'b1;
            end else if (i_req) begin
               gnt_d_d    = 1'b0;
               mem_addr_d = {i_addr[ADDR_W-1:1], 1'b0};
               mem_wr_d   = 1'b0;
               mem_en_d   = 1'b1;
               state_d    = ISSUE;
               if (i_addr[0]) err_d = 1'b1;
            end
         end
         ISSUE: begin
            cnt_d   = LAT_M1;
            state_d = (MEM_LAT == 1) ? DONE : WAIT;
         end
         WAIT: begin
            if (cnt_q <= 4'd1) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A fetch dropped at any point after grant is remembered so a late re-raise cannot resurrect it.
      if (state_q != IDLE && !gnt_d_q && !i_req) flush_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         gnt_d_q     <= 1'b0;
         flush_q     <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= 4'd0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_d_q     <= gnt_d_d;
         flush_q     <= flush_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign i_done    = (state_q == DONE) && !gnt_d_q && i_req && !flush_q;
   assign d_done    = (state_q == DONE) && gnt_d_q;
   assign i_rdata   = i_done ? mem_rdata : '0;
   assign d_rdata   = d_done ? mem_rdata : '0;
   assign i_stall   = i_req & ~i_done;
   assign d_stall   = (d_rd | d_wr) & ~d_done;
   assign err       = err_q;
   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
